// File: rtl/common_pkg.sv
// Shared data-bus types used by every bus agent in the core.
package common_pkg;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [1:0]  size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/mem_access_unit_pkg.sv
// Pipeline-side types and helpers for the memory-stage bus agent.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } mau_state_t;

  typedef struct packed {
    logic        is_store;
    mem_size_t   size;
    logic        is_unsigned;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_req_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] off);
    case (size)
      MSIZE1:  is_misaligned = 1'b0;
      MSIZE2:  is_misaligned = (off[0] != 1'b0);
      MSIZE4:  is_misaligned = (off[1:0] != 2'b00);
      MSIZE8:  is_misaligned = (off != 3'b000);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input mem_size_t size);
    case (size)
      MSIZE1:  size_mask = 8'h01;
      MSIZE2:  size_mask = 8'h03;
      MSIZE4:  size_mask = 8'h0F;
      MSIZE8:  size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store shifter/strobe generator and load extractor/extender.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  mem_size_t   st_size,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_wdata,
  output logic [7:0]  st_strobe,
  output logic [63:0] st_data,
  input  mem_size_t   ld_size,
  input  logic        ld_unsigned,
  input  logic [2:0]  ld_off,
  input  logic [63:0] ld_raw,
  output logic [63:0] ld_result
);

  logic [63:0] ld_shift_s;

  // Store lanes move up to the addressed byte; loads move down then extend.
  always_comb begin
    st_strobe  = size_mask(st_size) << st_off;
    st_data    = st_wdata << {st_off, 3'b000};
    ld_shift_s = ld_raw >> {ld_off, 3'b000};
    case (ld_size)
      MSIZE1:  ld_result = ld_unsigned ? {56'h0, ld_shift_s[7:0]}
                                       : {{56{ld_shift_s[7]}}, ld_shift_s[7:0]};
      MSIZE2:  ld_result = ld_unsigned ? {48'h0, ld_shift_s[15:0]}
                                       : {{48{ld_shift_s[15]}}, ld_shift_s[15:0]};
      MSIZE4:  ld_result = ld_unsigned ? {32'h0, ld_shift_s[31:0]}
                                       : {{32{ld_shift_s[31]}}, ld_shift_s[31:0]};
      MSIZE8:  ld_result = ld_shift_s;
      default: ld_result = 64'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage bus agent: one load/store per transaction, request held on the
// data bus until data_ok, registered result handed back to the pipeline.
module mem_access_unit
  import common_pkg::*;
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_misalign,
  input  logic        resp_ready,
  input  logic        flush,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp
);

  mau_state_t  state_r;
  dbus_req_t   dreq_r;
  mem_req_t    req_s;
  mem_size_t   size_r;
  logic        store_r, unsigned_r, resp_valid_r, resp_misalign_r;
  logic [2:0]  off_r;
  logic [63:0] resp_data_r;
  logic        req_ready_s, misaligned_s;
  logic [7:0]  st_strobe_s;
  logic [63:0] st_data_s, ld_result_s;
  logic        unused_addr_ok_s;

  // Bundle the pipeline request and classify its alignment.
  always_comb begin
    req_s.is_store    = req_is_store;
    req_s.size        = mem_size_t'(req_size);
    req_s.is_unsigned = req_unsigned;
    req_s.addr        = req_addr;
    req_s.wdata       = req_wdata;
    misaligned_s      = is_misaligned(req_s.size, req_s.addr[2:0]);
  end

  assign req_ready_s      = (state_r == S_IDLE) && !flush;
  assign unused_addr_ok_s = dresp.addr_ok;

  mem_align u_align (
    .st_size     (req_s.size),
    .st_off      (req_s.addr[2:0]),
    .st_wdata    (req_s.wdata),
    .st_strobe   (st_strobe_s),
    .st_data     (st_data_s),
    .ld_size     (size_r),
    .ld_unsigned (unsigned_r),
    .ld_off      (off_r),
    .ld_raw      (dresp.data),
    .ld_result   (ld_result_s)
  );

  // Transaction FSM; dreq is built once at acceptance and never touched until data_ok.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= S_IDLE;
      dreq_r          <= '0;
      resp_valid_r    <= 1'b0;
      resp_data_r     <= 64'h0;
      resp_misalign_r <= 1'b0;
      store_r         <= 1'b0;
      size_r          <= MSIZE1;
      unsigned_r      <= 1'b0;
      off_r           <= 3'b000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid && req_ready_s) begin
            store_r    <= req_s.is_store;
            size_r     <= req_s.size;
            unsigned_r <= req_s.is_unsigned;
            off_r      <= req_s.addr[2:0];
            if (misaligned_s) begin
              state_r         <= S_HOLD;
              resp_valid_r    <= 1'b1;
              resp_misalign_r <= 1'b1;
              resp_data_r     <= 64'h0;
            end else begin
              state_r       <= S_BUS;
              dreq_r.valid  <= 1'b1;
              dreq_r.addr   <= req_s.addr;
              dreq_r.size   <= req_s.size;
              dreq_r.strobe <= req_s.is_store ? st_strobe_s : 8'h00;
              dreq_r.data   <= req_s.is_store ? st_data_s : 64'h0;
            end
          end
        end
        S_BUS: begin
          if (dresp.data_ok) begin
            dreq_r <= '0;
            if (flush) begin
              state_r <= S_IDLE;
            end else begin
              state_r         <= S_HOLD;
              resp_valid_r    <= 1'b1;
              resp_misalign_r <= 1'b0;
              resp_data_r     <= store_r ? 64'h0 : ld_result_s;
            end
          end else if (flush) begin
            state_r <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (flush || resp_ready) begin
            state_r         <= S_IDLE;
            resp_valid_r    <= 1'b0;
            resp_data_r     <= 64'h0;
            resp_misalign_r <= 1'b0;
          end
        end
        // A flushed request still has to finish on the bus before we let go.
        S_DRAIN: begin
          if (dresp.data_ok) begin
            dreq_r  <= '0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          dreq_r       <= '0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_s;
  assign resp_valid    = resp_valid_r;
  assign resp_data     = resp_data_r;
  assign resp_misalign = resp_misalign_r;
  assign dreq          = dreq_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;
  import common_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_is_store, req_unsigned, resp_ready, flush;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_misalign;
  logic [63:0] resp_data;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_misalign(resp_misalign), .resp_ready(resp_ready),
    .flush(flush), .dreq(dreq), .dresp(dresp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // current transaction as seen by the reference model
  logic        cur_store = 1'b0, cur_uns = 1'b0;
  logic [1:0]  cur_size = 2'd0;
  logic [63:0] cur_addr = 64'h0, cur_wdata = 64'h0;
  int          bus_wait = 0, bus_cnt = 0;
  logic [63:0] bus_rdata = 64'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_nb(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic int m_off(input logic [63:0] a);
    return int'(a % 64'd8);
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [63:0] a);
    return (a % 64'(m_nb(sz))) != 64'd0;
  endfunction

  function automatic logic [7:0] m_strobe(input logic [1:0] sz, input logic [63:0] a);
    logic [15:0] s;
    s = ((16'h1 << m_nb(sz)) - 16'h1) << m_off(a);
    return s[7:0];
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] raw, input logic [1:0] sz,
                                         input logic [63:0] a, input logic uns);
    logic [63:0] v, mask;
    int nb;
    nb   = m_nb(sz);
    v    = raw >> (8 * m_off(a));
    mask = (nb == 8) ? ~64'h0 : ((64'h1 << (8 * nb)) - 64'h1);
    v    = v & mask;
    if (!uns && nb < 8 && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  // bus slave: data_ok after bus_wait cycles of dreq.valid
  always @(posedge clk) begin
    #1;
    dresp.data    = bus_rdata;
    dresp.addr_ok = dreq.valid;
    if (dreq.valid) begin
      dresp.data_ok = (bus_cnt == bus_wait);
      bus_cnt++;
    end else begin
      dresp.data_ok = 1'b0;
      bus_cnt = 0;
    end
  end

  // per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (dreq.valid) begin
        check("dreq_addr", dreq.addr, cur_addr);
        check("dreq_size", 64'(dreq.size), 64'(cur_size));
        check("dreq_strobe", 64'(dreq.strobe), cur_store ? 64'(m_strobe(cur_size, cur_addr)) : 64'h0);
        if (cur_store) check("dreq_data", dreq.data, cur_wdata << (8 * m_off(cur_addr)));
      end
      if (resp_valid) begin
        check("resp_misalign", 64'(resp_misalign), 64'(m_mis(cur_size, cur_addr)));
        check("resp_data", resp_data,
              (cur_store || m_mis(cur_size, cur_addr)) ? 64'h0
                                                       : m_load(bus_rdata, cur_size, cur_addr, cur_uns));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd);
    cur_store = st; cur_size = sz; cur_uns = uns; cur_addr = a; cur_wdata = wd;
    req_is_store = st; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    check("req_ready_idle", 64'(req_ready), 64'h1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output int vcnt);
    lat = 1; vcnt = 0;
    while (!resp_valid && lat < 20) begin
      if (dreq.valid) vcnt++;
      step();
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("resp_valid_cleared", 64'(resp_valid), 64'h0);
  endtask

  int lat, vcnt;
  logic [63:0] held;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h0; req_wdata = 64'h0; resp_ready = 1'b0; flush = 1'b0;
    dresp = '0;
    step(); step();
    check("rst_dreq_zero", 64'(dreq != '0), 64'h0);
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_resp_data", resp_data, 64'h0);
    check("rst_misalign", 64'(resp_misalign), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h1);
    reset = 1'b1;
    step();

    // load byte signed, two wait cycles
    bus_rdata = 64'h0000_0000_8000_0000; bus_wait = 2;
    issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0);
    wait_resp(lat, vcnt);
    check("lb_latency", 64'(lat), 64'd4);
    check("lb_valid_cycles", 64'(vcnt), 64'd3);
    check("lb_data", resp_data, 64'hFFFF_FFFF_FFFF_FF80);
    finish_resp();

    // store half at lane 6
    bus_rdata = 64'h0; bus_wait = 0;
    issue(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF);
    check("sh_strobe", 64'(dreq.strobe), 64'h0000_0000_0000_00C0);
    check("sh_data", 64'(dreq.data[63:48]), 64'h0000_0000_0000_BEEF);
    wait_resp(lat, vcnt);
    check("sh_latency", 64'(lat), 64'd2);
    check("sh_data_zero", resp_data, 64'h0);
    finish_resp();

    // misaligned word load
    issue(1'b0, 2'd2, 1'b1, 64'h8000_0002, 64'h0);
    wait_resp(lat, vcnt);
    check("mis_latency", 64'(lat), 64'd1);
    check("mis_no_bus", 64'(vcnt), 64'd0);
    check("mis_flag", 64'(resp_misalign), 64'h1);
    check("mis_data", resp_data, 64'h0);
    finish_resp();

    // flush in the second bus cycle, data_ok in the fourth
    bus_rdata = 64'h1111_2222_3333_4444; bus_wait = 3;
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0);
    vcnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (dreq.valid) vcnt++;
      check("fl_no_resp", 64'(resp_valid), 64'h0);
      if (c == 4) check("fl_valid_c4", 64'(dreq.valid), 64'h1);
      if (c == 5) check("fl_ready_c5", 64'(req_ready), 64'h1);
      if (c == 2) flush = 1'b1;
      step();
      flush = 1'b0;
    end
    check("fl_valid_cycles", 64'(vcnt), 64'd4);

    // flush alongside a request in IDLE: not accepted
    cur_store = 1'b0; cur_size = 2'd3; cur_addr = 64'h8000_0040;
    req_is_store = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0040;
    flush = 1'b1; req_valid = 1'b1;
    #1 check("flreq_ready", 64'(req_ready), 64'h0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    check("flreq_no_bus", 64'(dreq.valid), 64'h0);
    check("flreq_no_resp", 64'(resp_valid), 64'h0);
    step();

    // HOLD stalls for five cycles, then a back-to-back load
    bus_rdata = 64'h0000_0000_0000_8001; bus_wait = 0;
    issue(1'b0, 2'd1, 1'b0, 64'h8000_0020, 64'h0);
    wait_resp(lat, vcnt);
    check("hold_latency", 64'(lat), 64'd2);
    held = resp_data;
    check("hold_data", held, 64'hFFFF_FFFF_FFFF_8001);
    for (int c = 1; c <= 6; c++) begin
      check("hold_valid", 64'(resp_valid), 64'h1);
      check("hold_stable", resp_data, 64'hFFFF_FFFF_FFFF_8001);
      if (c == 6) resp_ready = 1'b1;
      step();
    end
    resp_ready = 1'b0;
    check("hold_released", 64'(resp_valid), 64'h0);
    bus_rdata = 64'hDEAD_BEEF_0000_0000;
    issue(1'b0, 2'd2, 1'b1, 64'h8000_0024, 64'h0);
    wait_resp(lat, vcnt);
    check("b2b_latency", 64'(lat), 64'd2);
    check("b2b_data", resp_data, 64'h0000_0000_DEAD_BEEF);
    finish_resp();

    // asynchronous reset in the middle of a bus access
    bus_rdata = 64'h0; bus_wait = 5;
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0030, 64'h0);
    step();
    #2 reset = 1'b0;
    #1;
    check("arst_dreq_zero", 64'(dreq != '0), 64'h0);
    check("arst_resp_valid", 64'(resp_valid), 64'h0);
    check("arst_req_ready", 64'(req_ready), 64'h1);
    step();
    reset = 1'b1;
    step();
    bus_rdata = 64'h0123_4567_89AB_CDEF; bus_wait = 1;
    issue(1'b0, 2'd3, 1'b0, 64'h8000_0008, 64'h0);
    wait_resp(lat, vcnt);
    check("post_rst_latency", 64'(lat), 64'd3);
    check("post_rst_data", resp_data, 64'h0123_4567_89AB_CDEF);
    finish_resp();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage bus agent between the pipeline's memory stage and the data bus (dbus_req_t / dbus_resp_t).
- Accepts one load or store per transaction from the pipeline and aligns store data and strobes.
- Holds the dbus request until data_ok, then extracts and sign/zero-extends load data.
- Returns a registered result and raises a stall-request handshake to the pipeline control while busy.

Parameters:
- None. Widths are fixed by the common package: 64-bit address and data, 8-bit strobe.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  memory-stage access present
req_is_store  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=double
req_unsigned  in  1  load zero-extends when 1
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned
req_ready  out  1  unit accepts a request this cycle
resp_valid  out  1  result available
resp_data  out  64  extended load data; 0 for stores
resp_misalign  out  1  address not aligned to size
resp_ready  in  1  pipeline consumes result
flush  in  1  squash in-flight access
dreq  out  dbus_req_t  data bus request
dresp  in  dbus_resp_t  data bus response

Behaviour:
- Reset (reset=0, asynchronous) clears everything:
  - state=IDLE; dreq all-zero; resp_valid=0, resp_data=0, resp_misalign=0; req_ready=1.
- FSM states: IDLE, BUS, HOLD, DRAIN.
- IDLE:
  - req_ready = !flush.
  - Accept on req_valid & req_ready; latch size, unsigned, addr[2:0] and store flag.
  - Aligned request → BUS next cycle.
  - Misaligned request (addr[0] for half, addr[1:0] for word, addr[2:0] for double nonzero) → HOLD with resp_misalign=1, resp_data=0, no bus access.
- BUS:
  - dreq.valid=1; addr, size, strobe and data stay constant until data_ok.
  - Store: strobe = size mask (1/3/F/FF) << addr[2:0]; data = wdata << 8*addr[2:0].
  - Load: strobe = 0.
  - On dresp.data_ok, drop dreq.valid the following cycle and go to HOLD.
  - Load result = (dresp.data >> 8*addr[2:0]) truncated to size, then sign- or zero-extended.
- HOLD:
  - resp_valid=1.
  - On resp_ready → IDLE, resp_valid=0 next cycle; the next request may be accepted in that following IDLE cycle.
- Latency: aligned access with data_ok in the first BUS cycle gives resp_valid 2 cycles after acceptance. Each extra wait cycle adds 1.
- Flush handling:
  - In BUS without data_ok → DRAIN. dreq stays valid and unchanged, because the bus must not see an abandoned request. On data_ok → IDLE, no response.
  - In BUS with data_ok in the same cycle → IDLE, result dropped.
  - In HOLD → IDLE, resp_valid=0 next cycle.
  - In DRAIN → no effect.
  - Flush together with req_valid in IDLE → request not accepted.
- dresp.addr_ok is ignored; data_ok alone completes a transaction.
- Reset mid-transaction returns to IDLE immediately; the bus model tolerates the dropped request.
- Stall interface: pipeline control stalls the memory stage whenever req_valid & !(resp_valid & resp_ready).

Decomposition:
- pipes package:
  - mem_size_t enum (MSIZE1/2/4/8);
  - mau_state_t enum;
  - mem_req_t struct {is_store, size, unsigned, addr, wdata}.
- common package: existing dbus_req_t / dbus_resp_t / strobe_t.
- One sub-module: mem_align, purely combinational. It contains the store shifter/strobe generator and the load extractor/extender, so the FSM file holds state only.

Test Plan:
- Load byte signed at addr 0x80000003, dresp.data=0x0000_0000_8000_0000 after 2 wait cycles → dreq.valid held 3 cycles with constant addr; resp_data=0xFFFF_FFFF_FFFF_FF80 four cycles after acceptance.
- Store half 0xBEEF at addr 0x80000006 → dreq.strobe=0xC0, dreq.data[63:48]=0xBEEF; resp_valid after data_ok with resp_data=0.
- Load word unsigned at 0x80000002 → no dreq.valid ever; resp_valid next cycle, resp_misalign=1, resp_data=0.
- Flush in the second BUS cycle, data_ok in the fourth → dreq.valid stays 1 until data_ok; no resp_valid; req_ready=1 the cycle after data_ok.
- HOLD with resp_ready=0 for 5 cycles, then 1 → resp_valid/resp_data stable all 6 cycles; back-to-back second load is accepted and completes.
- Assert reset=0 during BUS → all outputs zero asynchronously; after release, a fresh load double at 0x80000008 returns dresp.data unchanged.
